// File: rtl/mod_expt_pkg.sv
// Shared types and width helpers for the modular exponentiation engine.
package mod_expt_pkg;

   typedef enum logic [2:0] {IDLE, PRE, BIT, UPD, DONE} state_t;

   localparam int DEF_I_MSB = 2;
   localparam int DEF_J_MSB = 10;

   function automatic int width_from_msb(input int msb);
      return 1 << (msb + 1);
   endfunction

endpackage

// File: rtl/mod_mul_blakley.sv
// Blakley interleaved modular multiplier: result = a*b mod m in W cycles, MSB of a first.
// Operands are captured on start; result is valid from the cycle done is high until the next start.
module mod_mul_blakley #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] m,
   output logic         done,
   output logic [W-1:0] result
);

   localparam int CW = (W > 2) ? $clog2(W) : 1;

   logic [W+1:0]  acc;
   logic [W+1:0]  acc_nxt;
   logic [W+1:0]  b_r;
   logic [W+1:0]  m_r;
   logic [W-1:0]  a_sh;
   logic [CW-1:0] cnt;
   logic          busy;

   // With R < m and b < m the sum stays below 3m, so two conditional subtractions suffice.
   function automatic logic [W+1:0] step(input logic [W+1:0] r, input logic bit_i,
                                         input logic [W+1:0] bb, input logic [W+1:0] mm);
      logic [W+1:0] t;
      t = (r << 1) + (bit_i ? bb : '0);
      if (t >= mm) t = t - mm;
      if (t >= mm) t = t - mm;
      return t;
   endfunction

   always_comb begin
      acc_nxt = step(acc, a_sh[W-1], b_r, m_r);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc  <= '0;
         b_r  <= '0;
         m_r  <= '0;
         a_sh <= '0;
         cnt  <= '0;
         busy <= 1'b0;
      end else if (start) begin
         acc  <= step('0, a[W-1], {2'b00, b}, {2'b00, m});
         a_sh <= a << 1;
         b_r  <= {2'b00, b};
         m_r  <= {2'b00, m};
         cnt  <= CW'(W - 2);
         busy <= 1'b1;
      end else if (busy) begin
         acc  <= acc_nxt;
         a_sh <= a_sh << 1;
         cnt  <= cnt - 1'b1;
         if (cnt == '0) busy <= 1'b0;
      end
   end

   assign done   = busy && (cnt == '0);
   assign result = done ? acc_nxt[W-1:0] : acc[W-1:0];

endmodule

// File: rtl/mod_expt.sv
// Toggle-handshake modular exponentiation: tx_data = rx_data_1 ** rx_data_2 mod rx_data_3.
// Define REQ_SYNC_EN to pass req through a 2-flop synchronizer for an asynchronous requester.
module mod_expt
   import mod_expt_pkg::*;
#(
   parameter int I_MSB = DEF_I_MSB,
   parameter int J_MSB = DEF_J_MSB
) (
   input  logic                                 clk,
   input  logic                                 rstn,
   input  logic                                 enable,
   input  logic                                 req,
   output logic                                 ack,
   output logic [width_from_msb(I_MSB)-1:0]     tx_data,
   input  logic [width_from_msb(I_MSB)-1:0]     rx_data_1,
   input  logic [width_from_msb(J_MSB)-1:0]     rx_data_2,
   input  logic [width_from_msb(I_MSB)-1:0]     rx_data_3
);

   localparam int W = width_from_msb(I_MSB);
   localparam int E = width_from_msb(J_MSB);
   localparam logic [W-1:0] ONE = W'(1);

   state_t         state, state_nxt;
   logic           req_s;
   logic           served;
   logic           pending;
   logic [W-1:0]   base_r;
   logic [W-1:0]   res;
   logic [W-1:0]   mod_r;
   logic [E-1:0]   exp_r;
   logic [J_MSB:0] bit_idx;
   logic           mul_run;
   logic           mul_start;
   logic           mul_fin;
   logic [W-1:0]   mul0_a, mul0_b, prod0, prod1;
   logic           done0, done1;

`ifdef REQ_SYNC_EN
   logic [1:0] req_sync;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) req_sync <= '0;
      else       req_sync <= {req_sync[0], req};
   end

   assign req_s = req_sync[1];
`else
   assign req_s = req;
`endif

   assign pending = (req_s != served);

   // During PRE the multiply unit reduces the raw base as base*1; afterwards it forms res*base.
   assign mul0_a = (state == PRE) ? base_r : res;
   assign mul0_b = (state == PRE) ? ONE : base_r;

   mod_mul_blakley #(.W(W)) u_mul (
      .clk(clk), .rstn(rstn), .start(mul_start),
      .a(mul0_a), .b(mul0_b), .m(mod_r), .done(done0), .result(prod0)
   );

   mod_mul_blakley #(.W(W)) u_sqr (
      .clk(clk), .rstn(rstn), .start(mul_start && (state == BIT)),
      .a(base_r), .b(base_r), .m(mod_r), .done(done1), .result(prod1)
   );

   always_comb begin
      state_nxt = state;
      mul_start = 1'b0;
      mul_fin   = mul_run && done0 && ((state == PRE) || done1);
      case (state)
         IDLE: if (pending) state_nxt = PRE;
         PRE: begin
            mul_start = !mul_run;
            if (mul_fin) state_nxt = BIT;
         end
         BIT: begin
            mul_start = !mul_run;
            if (mul_fin) state_nxt = UPD;
         end
         UPD:     state_nxt = (bit_idx == '1) ? DONE : BIT;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (!enable) begin
         state_nxt = IDLE;
         mul_start = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= IDLE;
         served  <= 1'b0;
         ack     <= 1'b0;
         tx_data <= '0;
         base_r  <= '0;
         res     <= '0;
         mod_r   <= '0;
         exp_r   <= '0;
         bit_idx <= '0;
         mul_run <= 1'b0;
      end else begin
         state <= state_nxt;
         ack   <= 1'b0;
         if (mul_start)               mul_run <= 1'b1;
         else if (state_nxt != state) mul_run <= 1'b0;
         if (!enable) begin
            served <= req_s;
         end else begin
            case (state)
               IDLE: if (pending) begin
                  served  <= req_s;
                  base_r  <= rx_data_1;
                  exp_r   <= rx_data_2;
                  mod_r   <= rx_data_3;
                  bit_idx <= '0;
               end
               // A modulus of 0 or 1 forces an all-zero result, including for exponent 0.
               PRE: if (mul_fin) begin
                  base_r <= prod0;
                  res    <= (mod_r < W'(2)) ? '0 : ONE;
               end
               UPD: begin
                  if (exp_r[0]) res <= prod0;
                  base_r  <= prod1;
                  exp_r   <= exp_r >> 1;
                  bit_idx <= bit_idx + 1'b1;
               end
               DONE: begin
                  tx_data <= res;
                  ack     <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mod_expt.sv
// Self-checking bench for mod_expt, built with a reduced 64-bit exponent to keep runs short.
module tb_mod_expt;

   localparam int I_MSB = 2;
   localparam int J_MSB = 5;
   localparam int W = 1 << (I_MSB + 1);
   localparam int E = 1 << (J_MSB + 1);
`ifdef REQ_SYNC_EN
   localparam int LAT = 1 + W + E * (W + 1) + 1 + 2;
`else
   localparam int LAT = 1 + W + E * (W + 1) + 1;
`endif

   typedef struct {
      logic [W-1:0] base;
      logic [E-1:0] expo;
      logic [W-1:0] modu;
      logic [W-1:0] want;
   } vec_t;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         enable = 1'b0;
   logic         req = 1'b0;
   logic         ack;
   logic [W-1:0] tx_data;
   logic [W-1:0] rx_data_1 = '0;
   logic [E-1:0] rx_data_2 = '0;
   logic [W-1:0] rx_data_3 = '0;

   int checks = 0;
   int errors = 0;

   mod_expt #(.I_MSB(I_MSB), .J_MSB(J_MSB)) dut (
      .clk(clk), .rstn(rstn), .enable(enable), .req(req), .ack(ack),
      .tx_data(tx_data), .rx_data_1(rx_data_1), .rx_data_2(rx_data_2), .rx_data_3(rx_data_3)
   );

   always #5 clk = ~clk;

   // Reference powmod from plain integer arithmetic.
   function automatic logic [W-1:0] ref_powmod(input logic [W-1:0] b, input logic [E-1:0] e,
                                                input logic [W-1:0] m);
      longint unsigned r, x;
      if (m == 0) return '0;
      r = 1 % longint'(m);
      x = longint'(b) % longint'(m);
      for (int i = 0; i < E; i++) begin
         if (e[i]) r = (r * x) % longint'(m);
         x = (x * x) % longint'(m);
      end
      return W'(r);
   endfunction

   task automatic check_output(input string name, input longint unsigned got, input longint unsigned want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   task automatic apply_stimulus(input logic [W-1:0] b, input logic [E-1:0] e, input logic [W-1:0] m);
      @(posedge clk);
      #1;
      rx_data_1 = b;
      rx_data_2 = e;
      rx_data_3 = m;
      req = ~req;
   endtask

   task automatic wait_ack(output int cycles);
      cycles = 0;
      do begin
         @(posedge clk);
         @(negedge clk);
         cycles++;
      end while (!ack && cycles < LAT + 50);
   endtask

   task automatic run_op(input string name, input logic [W-1:0] b, input logic [E-1:0] e,
                         input logic [W-1:0] m, input logic [W-1:0] want);
      int cyc;
      apply_stimulus(b, e, m);
      wait_ack(cyc);
      check_output({name, " latency"}, cyc, LAT);
      check_output({name, " result"}, tx_data, want);
      @(posedge clk);
      @(negedge clk);
      check_output({name, " ack width"}, ack, 0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      vec_t vecs[7];
      int acks;
      int cyc;
      logic [W-1:0] rb, rm;
      logic [E-1:0] re;

      vecs[0] = '{base: 8'd3,   expo: E'(200), modu: 8'd7,  want: 8'd2};
      vecs[1] = '{base: 8'd5,   expo: E'(3),   modu: 8'd13, want: 8'd8};
      vecs[2] = '{base: 8'd200, expo: E'(1),   modu: 8'd7,  want: 8'd4};
      vecs[3] = '{base: 8'd17,  expo: E'(0),   modu: 8'd9,  want: 8'd1};
      vecs[4] = '{base: 8'd123, expo: E'(77),  modu: 8'd1,  want: 8'd0};
      vecs[5] = '{base: 8'd0,   expo: E'(5),   modu: 8'd11, want: 8'd0};
      vecs[6] = '{base: 8'd45,  expo: E'(10),  modu: 8'd0,  want: 8'd0};

      // Reset and idle behaviour
      repeat (10) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      check_output("reset ack", ack, 0);
      check_output("reset tx_data", tx_data, 0);
      enable = 1'b1;
      acks = 0;
      repeat (30) begin
         @(negedge clk);
         if (ack) acks++;
      end
      check_output("idle no ack", acks, 0);

      for (int i = 0; i < 7; i++)
         run_op($sformatf("vec%0d", i), vecs[i].base, vecs[i].expo, vecs[i].modu, vecs[i].want);

      for (int i = 0; i < 10; i++) begin
         rb = W'($urandom_range(0, 255));
         re = {$urandom, $urandom};
         if (re == '0) re = E'(1);
         rm = W'($urandom_range(1, 255));
         run_op($sformatf("rand%0d", i), rb, re, rm, ref_powmod(rb, re, rm));
      end

      // Second toggle while busy is queued and served right after the first ack
      apply_stimulus(8'd7, E'(5), 8'd100);
      repeat (100) @(posedge clk);
      #1;
      rx_data_1 = 8'd2;
      rx_data_2 = E'(10);
      rx_data_3 = 8'd251;
      req = ~req;
      wait_ack(cyc);
      check_output("queued first latency", cyc + 100, LAT);
      check_output("queued first result", tx_data, 7);
      wait_ack(cyc);
      check_output("queued second latency", cyc, LAT);
      check_output("queued second result", tx_data, 20);
      @(posedge clk);
      @(negedge clk);
      check_output("queued ack width", ack, 0);

      // Abort by enable, with a toggle dropped while disabled
      apply_stimulus(8'd9, E'(33), 8'd77);
      repeat (100) @(posedge clk);
      #1 enable = 1'b0;
      repeat (10) @(posedge clk);
      #1 req = ~req;
      repeat (10) @(posedge clk);
      #1 enable = 1'b1;
      acks = 0;
      repeat (LAT + 20) begin
         @(negedge clk);
         if (ack) acks++;
      end
      check_output("abort no ack", acks, 0);
      check_output("abort tx_data held", tx_data, 20);

      // Asynchronous reset mid-operation
      apply_stimulus(8'd11, E'(1000), 8'd97);
      repeat (100) @(posedge clk);
      #2 rstn = 1'b0;
      #1;
      check_output("midreset ack", ack, 0);
      check_output("midreset tx_data", tx_data, 0);
      req = 1'b0;
      repeat (5) @(posedge clk);
      #1 rstn = 1'b1;
      run_op("post reset", 8'd11, E'(1000), 8'd97, ref_powmod(8'd11, E'(1000), 8'd97));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
